// File: rtl/dmem_unloader_pkg.sv
// Shared definitions for the data-memory unloader.
//   state_e    : unloader FSM encoding (IDLE, READ, DRAIN, FIN)
//   WORD_BYTES : byte stride between consecutive dmem words
package dmem_unloader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/dmem_unloader_fifo.sv
// unloader_fifo: small synchronous FIFO that buffers dmem read returns
// between the read port and the output stream.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push_i        write push_data_i (a push into a full FIFO is accepted
//                 only together with a pop)
//   pop_i         discard the head entry (ignored when empty)
//   head_o        current head entry
//   count_o       number of valid entries
module unloader_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // A pop frees the head slot this cycle, so a full FIFO can still take a push.
    assign do_pop_s  = pop_i && (count_q != '0);
    assign do_push_s = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_s);

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop_s) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dmem_unloader.sv
// dmem_unloader: on a start pulse, reads word_count consecutive words from
// data memory starting at base_addr (word aligned) and streams each word with
// its byte address over a valid/ready port; done pulses after the last beat.
// Optional feature macro: DMEM_UNLOADER_ECC_EN adds out_serr (per-word ECC
// corrected flag) and serr_count (corrected words in the current run).
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start, base_addr,
//   word_count                run request (sampled in IDLE only)
//   dmem_re, dmem_raddr       dmem read request
//   dmem_rdata, dmem_s_err    read return, one cycle after dmem_re
//   out_valid/ready/data/
//   addr/last                 output stream
//   busy, done                run status
module dmem_unloader
    import dmem_unloader_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              dmem_re,
    output logic [ADDR_W-1:0] dmem_raddr,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_s_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef DMEM_UNLOADER_ECC_EN
    ,
    output logic              out_serr,
    output logic [CNT_W-1:0]  serr_count
`endif
);

`ifdef DMEM_UNLOADER_ECC_EN
    localparam int FLAG_W = 1;
`else
    localparam int FLAG_W = 0;
`endif
    // FIFO entry layout, LSB first: [serr], last, data, addr.
    localparam int LAST_POS = FLAG_W;
    localparam int DATA_LSB = FLAG_W + 1;
    localparam int ADDR_LSB = FLAG_W + 1 + DATA_W;
    localparam int ENT_W    = ADDR_W + DATA_W + 1 + FLAG_W;
    localparam int FCNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W    = FCNT_W + 1;

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   remain_q;
    logic               infl_q;
    logic [ADDR_W-1:0]  infl_addr_q;
    logic               infl_last_q;
    logic               busy_q;
    logic               done_q;
    logic [ENT_W-1:0]   push_data_s;
    logic [ENT_W-1:0]   head_s;
    logic [FCNT_W-1:0]  fifo_count_s;
    logic [OCC_W-1:0]   occ_s;
    logic               valid_s;
    logic               pop_s;
    logic               issue_s;
    logic               unused_bits_s;

`ifdef DMEM_UNLOADER_ECC_EN
    logic [CNT_W-1:0]   serr_count_q;
    assign push_data_s   = {infl_addr_q, dmem_rdata, infl_last_q, dmem_s_err};
    assign out_serr      = valid_s ? head_s[0] : 1'b0;
    assign serr_count    = serr_count_q;
    assign unused_bits_s = ^base_addr[1:0];
`else
    assign push_data_s   = {infl_addr_q, dmem_rdata, infl_last_q};
    assign unused_bits_s = ^{base_addr[1:0], dmem_s_err};
`endif

    unloader_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (infl_q),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (fifo_count_s)
    );

    assign valid_s = (fifo_count_s != '0);
    assign pop_s   = valid_s && out_ready;

    // Occupancy after this cycle's pop plus the read still in flight; issuing
    // only while this stays below depth guarantees the return has a free slot
    // and sustains one word per cycle when the consumer keeps up.
    assign occ_s   = OCC_W'(fifo_count_s) - OCC_W'(pop_s) + OCC_W'(infl_q);
    assign issue_s = (state_q == ST_READ) && (occ_s < OCC_W'(FIFO_DEPTH));

    assign dmem_re    = issue_s;
    assign dmem_raddr = addr_q;
    assign out_valid  = valid_s;
    assign out_data   = valid_s ? head_s[DATA_LSB +: DATA_W] : '0;
    assign out_addr   = valid_s ? head_s[ADDR_LSB +: ADDR_W] : '0;
    assign out_last   = valid_s ? head_s[LAST_POS] : 1'b0;
    assign busy       = busy_q;
    assign done       = done_q;

    // Run control FSM with read issue bookkeeping and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            infl_q       <= 1'b0;
            infl_addr_q  <= '0;
            infl_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef DMEM_UNLOADER_ECC_EN
            serr_count_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            infl_q <= issue_s;
            // busy rises with the accepted start and falls one cycle after FIN,
            // so it always brackets the done pulse.
            busy_q <= ((state_q == ST_IDLE) && start) || (state_q != ST_IDLE);
            if (issue_s) begin
                infl_addr_q <= addr_q;
                infl_last_q <= (remain_q == CNT_W'(1));
                addr_q      <= addr_q + ADDR_W'(WORD_BYTES);
                remain_q    <= remain_q - CNT_W'(1);
            end
`ifdef DMEM_UNLOADER_ECC_EN
            if (infl_q && dmem_s_err && (serr_count_q != '1)) begin
                serr_count_q <= serr_count_q + CNT_W'(1);
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q   <= {base_addr[ADDR_W-1:2], 2'b00};
                        remain_q <= word_count;
`ifdef DMEM_UNLOADER_ECC_EN
                        serr_count_q <= '0;
`endif
                        if (word_count == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue_s && (remain_q == CNT_W'(1))) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The last-flagged word is the final entry, so its pop empties the FIFO.
                    if (pop_s && head_s[LAST_POS]) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_unloader.sv
// Directed self-checking bench for dmem_unloader (ECC checks included when
// DMEM_UNLOADER_ECC_EN is defined).
module tb_dmem_unloader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic [9:0]  word_count = 10'd0;
    logic        dmem_re;
    logic [31:0] dmem_raddr;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_s_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef DMEM_UNLOADER_ECC_EN
    logic        out_serr;
    logic [9:0]  serr_count;
`endif

    dmem_unloader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .dmem_re    (dmem_re),
        .dmem_raddr (dmem_raddr),
        .dmem_rdata (dmem_rdata),
        .dmem_s_err (dmem_s_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
`ifdef DMEM_UNLOADER_ECC_EN
        ,
        .out_serr   (out_serr),
        .serr_count (serr_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // dmem model: 16 words, 1-cycle read latency
    logic [31:0] mem      [16];
    logic        mem_serr [16];
    always @(posedge clk) begin
        if (dmem_re) begin
            dmem_rdata <= mem[dmem_raddr[5:2]];
            dmem_s_err <= mem_serr[dmem_raddr[5:2]];
        end
    end

    // negedge monitor
    logic        mon_clr = 1'b0;
    int          re_count, busy_count, done_count, valid_count, stall_err;
    int          first_re, last_re, first_valid, done_cyc, last_beat_cyc;
    logic        prev_stall;
    logic [31:0] prev_addr, prev_data;
    logic        prev_last;
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    logic        q_last [$];
    logic        q_serr [$];

    always @(negedge clk) begin
        if (mon_clr) begin
            re_count <= 0; busy_count <= 0; done_count <= 0; valid_count <= 0;
            stall_err <= 0; first_re <= -1; last_re <= -1; first_valid <= -1;
            done_cyc <= -1; last_beat_cyc <= -1; prev_stall <= 1'b0;
            q_addr.delete(); q_data.delete(); q_last.delete(); q_serr.delete();
        end else begin
            if (dmem_re) begin
                re_count <= re_count + 1;
                if (first_re < 0) first_re <= cyc;
                last_re <= cyc;
            end
            if (busy) busy_count <= busy_count + 1;
            if (done) begin
                done_count <= done_count + 1;
                done_cyc   <= cyc;
            end
            if (out_valid) begin
                valid_count <= valid_count + 1;
                if (first_valid < 0) first_valid <= cyc;
            end
            if (prev_stall && (!out_valid || out_addr !== prev_addr ||
                               out_data !== prev_data || out_last !== prev_last))
                stall_err <= stall_err + 1;
            prev_stall <= out_valid && !out_ready;
            prev_addr  <= out_addr;
            prev_data  <= out_data;
            prev_last  <= out_last;
            if (out_valid && out_ready) begin
                q_addr.push_back(out_addr);
                q_data.push_back(out_data);
                q_last.push_back(out_last);
`ifdef DMEM_UNLOADER_ECC_EN
                q_serr.push_back(out_serr);
`else
                q_serr.push_back(1'b0);
`endif
                last_beat_cyc <= cyc;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: out_ready high; mode 1: out_ready toggles each cycle.
    // extra_at: loop iteration at which a second start pulse is driven (-1 none).
    task automatic run(input logic [31:0] base, input logic [9:0] cnt,
                       input int mode, input int extra_at);
        @(posedge clk); #1;
        mon_clr   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        mon_clr    = 1'b0;
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < 200; i++) begin
            if (mode == 1) out_ready = ~out_ready;
            if (i == extra_at) begin
                start      = 1'b1;
                base_addr  = 32'h40;
                word_count = 10'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done_count != 0 && cyc > done_cyc + 3) break;
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_beats(input string tag, input logic [31:0] exp_base, input int n,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] ea;
        logic [31:0] ed;
        check_eq($sformatf("%s_nbeats", tag), q_addr.size(), n);
        for (int i = 0; i < n && i < q_addr.size(); i++) begin
            ea = exp_base + 32'(4 * i);
            ed = (i == 0) ? d0 : (i == 1) ? d1 : (i == 2) ? d2 : d3;
            check_eq($sformatf("%s_addr%0d", tag, i), q_addr[i], ea);
            check_eq($sformatf("%s_data%0d", tag, i), q_data[i], ed);
            check_eq($sformatf("%s_last%0d", tag, i), q_last[i], (i == n - 1));
        end
        check_eq($sformatf("%s_done", tag), done_count, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]      = 32'hDEAD_0000 + 32'(i);
            mem_serr[i] = 1'b0;
        end
        mem[0]  = 32'd1;
        mem[1]  = 32'd2;
        mem[2]  = 32'd3;
        mem[3]  = 32'd4;
        mem[14] = 32'hAAAA_0014;
        mem[15] = 32'hAAAA_0015;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_re", dmem_re, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: four words, consumer always ready
        run(32'h0, 10'd4, 0, -1);
        check_beats("t1", 32'h0, 4, 32'd1, 32'd2, 32'd3, 32'd4);
        check_eq("t1_re_count", re_count, 4);
        check_eq("t1_re_span", last_re - first_re, 3);
        check_eq("t1_first_valid_lat", first_valid - start_cyc, 2);
        check_eq("t1_done_lat", done_cyc - last_beat_cyc, 1);
        check_eq("t1_stall", stall_err, 0);

        // 2: consumer ready toggles each cycle
        run(32'h0, 10'd4, 1, -1);
        check_beats("t2", 32'h0, 4, 32'd1, 32'd2, 32'd3, 32'd4);
        check_eq("t2_re_count", re_count, 4);
        check_eq("t2_re_throttled", (last_re - first_re) > 3, 1'b1);
        check_eq("t2_stall", stall_err, 0);

        // 3: zero-length run
        run(32'h0, 10'd0, 0, -1);
        check_eq("t3_valid", valid_count, 0);
        check_eq("t3_done", done_count, 1);
        check_eq("t3_busy_cycles", busy_count, 2);
        check_eq("t3_re", re_count, 0);

        // 4: address wrap; low address bits ignored
        run(32'hFFFF_FFFB, 10'd3, 0, -1);
        check_beats("t4", 32'hFFFF_FFF8, 3, 32'hAAAA_0014, 32'hAAAA_0015, 32'd1, 32'd0);

        // 5a: start while busy is ignored
        run(32'h0, 10'd4, 0, 1);
        check_beats("t5a", 32'h0, 4, 32'd1, 32'd2, 32'd3, 32'd4);
        check_eq("t5a_re_count", re_count, 4);

        // 5b: reset mid-run with a stalled consumer
        @(posedge clk); #1;
        mon_clr   = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        mon_clr    = 1'b0;
        base_addr  = 32'h0;
        word_count = 10'd4;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t5b_valid_before", out_valid, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5b_valid", out_valid, 1'b0);
        check_eq("t5b_data", out_data, 32'h0);
        check_eq("t5b_addr", out_addr, 32'h0);
        check_eq("t5b_last", out_last, 1'b0);
        check_eq("t5b_busy", busy, 1'b0);
        check_eq("t5b_done", done, 1'b0);
        check_eq("t5b_re", dmem_re, 1'b0);
        @(posedge clk); #1;
        rst       = 1'b1;
        out_ready = 1'b1;

        // 5c: clean run after reset
        run(32'h4, 10'd2, 0, -1);
        check_beats("t5c", 32'h4, 2, 32'd2, 32'd3, 32'd0, 32'd0);
        check_eq("t5c_re_count", re_count, 2);

`ifdef DMEM_UNLOADER_ECC_EN
        // 6: corrected-error flag on word 2 of 4
        mem_serr[1] = 1'b1;
        run(32'h0, 10'd4, 0, -1);
        check_beats("t6", 32'h0, 4, 32'd1, 32'd2, 32'd3, 32'd4);
        for (int i = 0; i < 4 && i < q_serr.size(); i++) begin
            check_eq($sformatf("t6_serr%0d", i), q_serr[i], (i == 1));
        end
        check_eq("t6_serr_count", serr_count, 10'd1);
        mem_serr[1] = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
